// File: rtl/alu_result_sel_pipe.sv
// Result-select stage: picks one of N_IN operation results by in_sel and
// forwards it through a two-entry skid buffer with a registered in_ready.
module alu_result_sel_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N_IN  = 10,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      err_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [SEL_W:0] LP_N_IN = (SEL_W+1)'(N_IN);

    state_t             r_state, w_next_state;
    logic [WIDTH-1:0]   r_main_data, r_skid_data, w_sel_data;
    logic               r_main_err, r_skid_err;
    logic               r_main_valid, r_skid_valid;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_err_count;

    logic w_sel_legal, w_accept, w_transfer;
    logic w_load_main_in, w_load_skid_in, w_main_from_skid;
    logic w_main_clear, w_skid_clear;

    assign w_sel_legal = ({1'b0, in_sel} < LP_N_IN);
    assign w_accept    = in_valid && r_in_ready;
    assign w_transfer  = r_main_valid && out_ready;

    // Exact-match decode: indices at or beyond N_IN fall through to zero.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_skid_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_clear     = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main_in = 1'b1;
                    w_next_state   = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_transfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid_in = 1'b1;
                    w_next_state   = TWO;
                end else if (w_transfer) begin
                    w_main_clear   = 1'b1;
                    w_next_state   = EMPTY;
                end
            end
            TWO: begin
                if (w_transfer) begin
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                    w_next_state     = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
            if (w_load_main_in) begin
                r_main_data  <= w_sel_data;
                r_main_err   <= !w_sel_legal;
                r_main_valid <= 1'b1;
            end else if (w_main_from_skid) begin
                r_main_data  <= r_skid_data;
                r_main_err   <= r_skid_err;
                r_main_valid <= r_skid_valid;
            end else if (w_main_clear) begin
                r_main_valid <= 1'b0;
            end
            if (w_load_skid_in) begin
                r_skid_data  <= w_sel_data;
                r_skid_err   <= !w_sel_legal;
                r_skid_valid <= 1'b1;
            end else if (w_skid_clear) begin
                r_skid_data  <= '0;
                r_skid_err   <= 1'b0;
                r_skid_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= (w_accept && !w_sel_legal) ? CNT_W'(1) : '0;
        end else if (w_accept && !w_sel_legal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_data    = r_main_data;
    assign out_sel_err = r_main_err;
    assign out_valid   = r_main_valid;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed and scoreboarded checks for alu_result_sel_pipe; inputs change and
// outputs are sampled on the falling clock edge.
module tb_alu_result_sel_pipe;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned N_IN  = 10;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_sel_err;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_clr;
    logic [CNT_W-1:0]      err_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH:0] sb_q[$];

    always #5 clk = ~clk;

    alu_result_sel_pipe #(
        .WIDTH(WIDTH),
        .N_IN (N_IN),
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel_err(out_sel_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] expect_word(input logic [SEL_W-1:0] sel);
        if (sel < N_IN) return {1'b0, 64'h1000 + 64'(sel)};
        return {1'b1, 64'h0};
    endfunction

    // Called at a falling edge once inputs for the coming rising edge are set.
    task automatic sb_eval();
        logic acc, xfer;
        logic [WIDTH:0] exp_w;
        chk("sb_out_valid", out_valid, sb_q.size() != 0);
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer && sb_q.size() != 0) begin
            exp_w = sb_q.pop_front();
            chk("sb_word", {out_sel_err, out_data}, exp_w);
        end
        if (acc) begin
            sb_q.push_back(expect_word(in_sel));
            chk("sb_inflight_le2", sb_q.size() <= 2, 1'b1);
        end
    endtask

    initial begin
        for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = 64'h1000 + 64'(k);
        rst_n = 1'b0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_sel_err", out_sel_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err_count", err_count, 8'd0);
        rst_n = 1'b1;

        // Stream 0..9 with no backpressure: one word per cycle, one cycle latency.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_sel = SEL_W'(k);
            @(negedge clk);
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_data", out_data, 64'h1000 + 64'(k));
            chk("stream_err", out_sel_err, 1'b0);
            chk("stream_in_ready", in_ready, 1'b1);
        end
        in_sel = 4'd3;
        @(negedge clk);
        chk("alias_sel3", out_data, 64'h1003);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_empty", out_valid, 1'b0);
        chk("err_cnt_after_stream", err_count, 8'd0);

        // Illegal selects and counter saturation/clear.
        in_valid = 1'b1; in_sel = 4'd12;
        @(negedge clk);
        chk("illegal_data", out_data, 64'h0);
        chk("illegal_err", out_sel_err, 1'b1);
        chk("illegal_cnt1", err_count, 8'd1);
        repeat (300) @(negedge clk);
        chk("cnt_saturate", err_count, 8'd255);
        in_valid = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        chk("cnt_clr_alone", err_count, 8'd0);
        in_valid = 1'b1; in_sel = 4'd15;
        @(negedge clk);
        chk("cnt_clr_with_illegal", err_count, 8'd1);
        err_clr = 1'b0; in_sel = 4'd3;
        @(negedge clk);
        chk("cnt_hold_legal", err_count, 8'd1);
        chk("legal_after_illegal", {out_sel_err, out_data}, {1'b0, 64'h1003});
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: A=1, B=2, C=5.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd1;
        @(negedge clk);
        chk("bp_A_valid", out_valid, 1'b1);
        chk("bp_A_data", out_data, 64'h1001);
        chk("bp_ready_one", in_ready, 1'b1);
        in_sel = 4'd2;
        @(negedge clk);
        chk("bp_ready_two", in_ready, 1'b0);
        chk("bp_A_hold1", out_data, 64'h1001);
        in_sel = 4'd5;
        repeat (3) begin
            @(negedge clk);
            chk("bp_C_blocked", in_ready, 1'b0);
            chk("bp_A_stable", {out_sel_err, out_data}, {1'b0, 64'h1001});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_B_data", out_data, 64'h1002);
        chk("bp_ready_back", in_ready, 1'b1);
        @(negedge clk);
        chk("bp_C_data", out_data, 64'h1005);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid, 1'b0);

        // Random valid/ready against a scoreboard, then drain.
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_sel    = SEL_W'($urandom_range(0, 15));
            sb_eval();
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sb_eval();
            @(negedge clk);
        end
        chk("sb_all_delivered", sb_q.size(), 0);

        // Reset while holding two words.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd8;
        repeat (2) @(negedge clk);
        chk("pre_rst_two", in_ready, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sel = 4'd7;
        @(negedge clk);
        chk("post_rst_first", {out_valid, out_data}, {1'b1, 64'h1007});
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_no_stale", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
